// File: rtl/mio_responder_if.sv
// CPU-side memory/IO bus between the core and mio_responder.
// Request fields from the CPU, read data and completion pulse back to it.
interface mio_responder_if;
    logic        CPU_MIO;
    logic        mem_w;
    logic [31:0] Addr_in;
    logic [31:0] Data_in;
    logic [31:0] Data_out;
    logic        MIO_ready;

    modport master (
        output CPU_MIO, mem_w, Addr_in, Data_in,
        input  Data_out, MIO_ready
    );

    modport slave (
        input  CPU_MIO, mem_w, Addr_in, Data_in,
        output Data_out, MIO_ready
    );
endinterface

// File: rtl/mio_responder.sv
// Memory/IO responder: 64-word RAM, LED, switches and a compare timer.
// Each request runs IDLE -> ACCESS -> DONE; MIO_ready pulses in DONE.
module mio_responder (
    input  logic              clk,
    input  logic              reset,
    mio_responder_if.slave    bus,
    input  logic [15:0]       sw_in,
    output logic [15:0]       led_out,
    output logic              INT
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [29:0] W_LED = 30'h3C00_0000;
    localparam logic [29:0] W_SW  = 30'h3C00_0001;
    localparam logic [29:0] W_CMP = 30'h3C00_0002;
    localparam logic [29:0] W_CNT = 30'h3C00_0003;
    localparam logic [29:0] W_ISR = 30'h3C00_0004;

    state_t      state;
    logic [29:0] word_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic [31:0] ram [0:63];
    logic [15:0] led_q;
    logic [31:0] cmp_q;
    logic [31:0] cnt_q;
    logic        pend_q;
    logic [31:0] dout_q;
    logic        ready_q;
    logic [31:0] rdata_d;

    logic sel_ram, sel_led, sel_sw, sel_cmp, sel_cnt, sel_isr;
    logic commit, match;

    assign sel_ram = (word_q[29:6] == 24'h0);
    assign sel_led = (word_q == W_LED);
    assign sel_sw  = (word_q == W_SW);
    assign sel_cmp = (word_q == W_CMP);
    assign sel_cnt = (word_q == W_CNT);
    assign sel_isr = (word_q == W_ISR);

    assign commit = (state == ACCESS) && we_q;
    assign match  = (cmp_q != 32'h0) && (cnt_q == cmp_q);

    assign bus.Data_out  = dout_q;
    assign bus.MIO_ready = ready_q;
    assign led_out       = led_q;
    assign INT           = pend_q;

    // Read mux over the latched address; unmapped words read 0.
    always_comb begin
        rdata_d = 32'h0;
        unique case (1'b1)
            sel_ram: rdata_d = ram[word_q[5:0]];
            sel_led: rdata_d = {16'h0, led_q};
            sel_sw:  rdata_d = {16'h0, sw_in};
            sel_cmp: rdata_d = cmp_q;
            sel_cnt: rdata_d = cnt_q;
            sel_isr: rdata_d = {31'h0, pend_q};
            default: rdata_d = 32'h0;
        endcase
    end

    // Transaction FSM with registered completion, read data and LED.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            word_q  <= 30'h0;
            wdata_q <= 32'h0;
            we_q    <= 1'b0;
            dout_q  <= 32'h0;
            ready_q <= 1'b0;
            led_q   <= 16'h0;
        end else begin
            unique case (state)
                IDLE: begin
                    ready_q <= 1'b0;
                    if (bus.CPU_MIO) begin
                        word_q  <= bus.Addr_in[31:2];
                        wdata_q <= bus.Data_in;
                        we_q    <= bus.mem_w;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    state   <= DONE;
                    ready_q <= 1'b1;
                    dout_q  <= we_q ? 32'h0 : rdata_d;
                    if (we_q && sel_led)
                        led_q <= wdata_q[15:0];
                end
                DONE: begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // RAM keeps its contents through reset; writes land at ACCESS->DONE.
    always_ff @(posedge clk) begin
        if (!reset && commit && sel_ram)
            ram[word_q[5:0]] <= wdata_q;
    end

    // Timer: match beats both CPU count clear and CPU pending clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmp_q  <= 32'h0;
            cnt_q  <= 32'h0;
            pend_q <= 1'b0;
        end else begin
            if (commit && sel_cmp)
                cmp_q <= wdata_q;
            if (match || (commit && sel_cnt))
                cnt_q <= 32'h0;
            else if (cmp_q != 32'h0)
                cnt_q <= cnt_q + 32'h1;
            if (match)
                pend_q <= 1'b1;
            else if (commit && sel_isr && wdata_q[0])
                pend_q <= 1'b0;
        end
    end

endmodule
